// File: rtl/mem_arbiter.sv
// Arbiter for the single-port unified memory, shared by the fetch port and the data port.
// Data wins ties; after STARVE_MAX contested data grants the fetch port is forced through.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MEM_LAT    = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic              port_d;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [STV_W-1:0]  starve_cnt_q, starve_cnt_d;
    req_t              req_q, req_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic              busy_q, busy_d;

    logic pick_i, pick_d, can_accept;

    // Fetch wins only when alone or when data has starved it STARVE_MAX times.
    assign pick_i     = i_req & (~d_req | (starve_cnt_q == STV_MAX));
    assign pick_d     = d_req & ~pick_i;
    assign can_accept = rst & (state_q == IDLE);
    assign i_ready    = can_accept & pick_i;
    assign d_ready    = can_accept & pick_d;

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        req_d        = req_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        mem_en_d     = mem_en_q;
        mem_wr_d     = mem_wr_q;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (i_ready || d_ready) begin
                    state_d      = ACCESS;
                    lat_cnt_d    = '0;
                    req_d.port_d = d_ready;
                    req_d.wr     = d_ready & d_wr;
                    req_d.addr   = d_ready ? d_addr : i_addr;
                    req_d.wdata  = d_ready ? d_wdata : '0;
                    mem_en_d     = 1'b1;
                    mem_wr_d     = d_ready & d_wr;
                    busy_d       = 1'b1;
                    if (i_ready) begin
                        starve_cnt_d = '0;
                    end else if (i_req && starve_cnt_q != STV_MAX) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end
            ACCESS: begin
                lat_cnt_d = lat_cnt_q + 1'b1;
                if (lat_cnt_q == LAT_LAST) begin
                    state_d  = DONE;
                    mem_en_d = 1'b0;
                    mem_wr_d = 1'b0;
                    i_done_d = ~req_q.port_d;
                    d_done_d = req_q.port_d;
                    if (!req_q.wr) begin
                        if (req_q.port_d) d_rdata_d = mem_rdata;
                        else              i_rdata_d = mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_wr_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            req_q        <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            req_q        <= req_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            mem_en_q     <= mem_en_d;
            mem_wr_q     <= mem_wr_d;
            busy_q       <= busy_d;
        end
    end

    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction table plus reset, contention and abandon sequences.
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_ready, i_done, d_ready, d_done;
    logic [15:0] i_rdata, d_rdata;
    logic        mem_en, mem_wr, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] mem [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Behavioural memory: combinational read, write on the clock edge.
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_en && mem_wr) mem[mem_addr[7:0]] <= mem_wdata;

    typedef struct {
        logic        i_req;
        logic [15:0] i_addr;
        logic        d_req;
        logic        d_wr;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic        exp_i;
        logic [15:0] exp_i_rdata;
        logic [15:0] exp_d_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%b exp=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold both requests; bit g of exp_i says whether grant g must go to fetch.
    task automatic contend(input int n, input logic [15:0] exp_i);
        logic got;
        i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
        i_addr = 16'h0040; d_addr = 16'h0050;
        for (int g = 0; g < n; g++) begin
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                #1;
                if (i_ready || d_ready) begin
                    chk1("contend_grant_is_fetch", i_ready, exp_i[g]);
                    chk1("contend_single_ready", i_ready & d_ready, 1'b0);
                    got = 1'b1;
                end
                tick();
            end
            if (!got) chk1("contend_timeout", 1'b0, 1'b1);
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (MEM_LAT + 1) tick();
        chk1("contend_idle_after", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ea;
        logic        ew;
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        mem[8'h10] = 16'h1234;
        mem[8'h30] = 16'h5A5A;

        //        i_req i_addr    d_req d_wr d_addr    d_wdata   exp_i exp_i_rdata exp_d_rdata
        vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 16'h0000};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h1234, 16'h5A5A};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 16'h1234, 16'h5A5A};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h1234, 16'hBEEF};
        vecs[4] = '{1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 16'hBEEF};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'hC0DE, 1'b0, 16'hBEEF, 16'hBEEF};
        vecs[6] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hC0DE, 16'hBEEF};

        // Reset with both requests asserted.
        rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
        i_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
        repeat (2) begin
            tick();
            chk1("rst_mem_en", mem_en, 1'b0);
            chk1("rst_i_ready", i_ready, 1'b0);
            chk1("rst_d_ready", d_ready, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_done", i_done | d_done, 1'b0);
            chk16("rst_d_rdata", d_rdata, 16'h0000);
        end
        rst = 1'b1;
        #1;
        chk1("post_rst_d_ready", d_ready, 1'b1);
        chk1("post_rst_i_ready", i_ready, 1'b0);
        i_req = 1'b0; d_req = 1'b0;
        tick();
        chk1("post_rst_no_access", mem_en, 1'b0);

        // Table of single-requester transactions.
        for (int v = 0; v < 7; v++) begin
            i_req = vecs[v].i_req; i_addr = vecs[v].i_addr;
            d_req = vecs[v].d_req; d_wr = vecs[v].d_wr;
            d_addr = vecs[v].d_addr; d_wdata = vecs[v].d_wdata;
            ea = vecs[v].exp_i ? vecs[v].i_addr : vecs[v].d_addr;
            ew = ~vecs[v].exp_i & vecs[v].d_wr;
            #1;
            chk1("tbl_i_ready", i_ready, vecs[v].exp_i);
            chk1("tbl_d_ready", d_ready, ~vecs[v].exp_i);
            chk1("tbl_idle_busy", busy, 1'b0);
            tick();
            // Post-accept inputs must be ignored.
            i_req = 1'b0; d_req = 1'b0; d_wr = ~vecs[v].d_wr;
            i_addr = 16'hFFFF; d_addr = 16'hFFFF; d_wdata = 16'h0BAD;
            for (int k = 0; k < MEM_LAT; k++) begin
                #1;
                chk1("tbl_mem_en", mem_en, 1'b1);
                chk16("tbl_mem_addr", mem_addr, ea);
                chk1("tbl_mem_wr", mem_wr, ew);
                if (ew) chk16("tbl_mem_wdata", mem_wdata, vecs[v].d_wdata);
                chk1("tbl_busy", busy, 1'b1);
                chk1("tbl_early_done", i_done | d_done, 1'b0);
                tick();
            end
            #1;
            chk1("tbl_i_done", i_done, vecs[v].exp_i);
            chk1("tbl_d_done", d_done, ~vecs[v].exp_i);
            chk16("tbl_i_rdata", i_rdata, vecs[v].exp_i_rdata);
            chk16("tbl_d_rdata", d_rdata, vecs[v].exp_d_rdata);
            chk1("tbl_done_mem_en", mem_en, 1'b0);
            chk1("tbl_done_busy", busy, 1'b1);
            tick();
            chk1("tbl_done_pulse", i_done | d_done, 1'b0);
            chk1("tbl_back_idle", busy, 1'b0);
        end

        // Sustained contention: D,D,D,I,D,D,D,I.
        contend(8, 16'b1000_1000);

        // Abandoned fetch request during a data grant: starve count rises by exactly one.
        i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0070;
        #1;
        chk1("abandon_d_ready", d_ready, 1'b1);
        chk1("abandon_i_ready", i_ready, 1'b0);
        tick();
        i_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k <= MEM_LAT; k++) begin
            #1;
            chk1("abandon_no_i_done", i_done, 1'b0);
            chk1("abandon_d_done", d_done, (k == MEM_LAT));
            tick();
        end
        repeat (3) begin
            chk1("abandon_no_fetch", mem_en, 1'b0);
            tick();
        end
        contend(3, 16'b100);

        // Reset in the second ACCESS cycle of a contested data grant.
        i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0030;
        #1;
        chk1("midrst_d_ready", d_ready, 1'b1);
        tick();
        i_req = 1'b0; d_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk1("midrst_mem_en", mem_en, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk16("midrst_d_rdata", d_rdata, 16'h0000);
        chk16("midrst_i_rdata", i_rdata, 16'h0000);
        rst = 1'b1;
        repeat (6) begin
            tick();
            chk1("midrst_no_done", i_done | d_done, 1'b0);
            chk1("midrst_no_mem_en", mem_en, 1'b0);
        end
        contend(4, 16'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
